// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared types, opcode encodings and ALU helper for the
//                multicycle 9-bit core.
//                Instruction word: op = [8:6], a = [5:3], b = [2:0].
//  Revision    : 1.0  initial multicycle release
// ============================================================================
package mc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_BZ   = 3'b111;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    // The ALU works at a fixed wide width; callers truncate to DATA_W. The
    // low DATA_W bits of add/sub/and/xor are unaffected by the extra width,
    // so wrap-around modulo 2^DATA_W falls out of the truncation.
    localparam int ALU_W = 64;

    function automatic logic [ALU_W-1:0] alu_f(
        input logic [2:0]       op,
        input logic [ALU_W-1:0] x,
        input logic [ALU_W-1:0] y
    );
        logic [ALU_W-1:0] res;
        res = x;
        case (op)
            OP_ADD, OP_ADDI: res = x + y;
            OP_SUB:          res = x - y;
            OP_AND:          res = x & y;
            OP_XOR:          res = x ^ y;
            default:         res = x;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mc_regfile
//  Description : 8 x DATA_W register file, two asynchronous read ports and
//                one synchronous write port, asynchronously cleared.
//  Ports       : clk             rising-edge clock
//                reset           asynchronous active-low clear
//                we/waddr/wdata  write port
//                raddr_a/rdata_a read port A
//                raddr_b/rdata_b read port B
//  Revision    : 1.0  initial multicycle release
// ============================================================================
module mc_regfile
    import mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a = r_regs[raddr_a];
    assign rdata_b = r_regs[raddr_b];

endmodule
`default_nettype wire

// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_core
//  Description : Multicycle 9-bit processor. FETCH/EXEC/MEM/WB sequencing
//                with req/ack instruction and data memory ports, start/idle
//                handshake, sticky halt, saturating cycle/retire counters.
//  Ports       : clk, reset (async active-low), start
//                imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch
//                dmem_req/dmem_we/dmem_addr/dmem_wdata/
//                dmem_ack/dmem_rdata                      data access
//                busy, done, cycle_count, retired         status
//  Revision    : 1.0  initial multicycle release
// ============================================================================
module multicycle_core
    import mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 12,
    parameter int DONE_PC = 2000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [8:0]        imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [PC_W-1:0] C_DONE_PC = PC_W'(DONE_PC);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [8:0]        r_ir;
    logic [CNT_W-1:0]  r_cycles;
    logic [CNT_W-1:0]  r_retired;

    logic [2:0]        w_op;
    logic [2:0]        w_ra;
    logic [2:0]        w_rb;
    logic signed [2:0] w_rb_s;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_alu_res;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_bz;
    logic [CNT_W-1:0]  w_retired_inc;
    logic              w_busy;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;

    assign w_op   = r_ir[8:6];
    assign w_ra   = r_ir[5:3];
    assign w_rb   = r_ir[2:0];
    assign w_rb_s = r_ir[2:0];

    mc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (w_rf_we),
        .waddr   (w_ra),
        .wdata   (w_rf_wdata),
        .raddr_a (w_ra),
        .rdata_a (w_rdata_a),
        .raddr_b (w_rb),
        .rdata_b (w_rdata_b)
    );

    // ADDI uses the b field as a zero-extended immediate instead of R[b].
    assign w_alu_y   = (w_op == OP_ADDI) ? DATA_W'(w_rb) : w_rdata_b;
    assign w_alu_res = DATA_W'(alu_f(w_op, ALU_W'(w_rdata_a), ALU_W'(w_alu_y)));

    // Register writes only happen in WB (ALU) or on the ack of a load; the
    // operands stay stable through MEM because nothing else writes then.
    assign w_rf_we    = (r_state == WB) ||
                        ((r_state == MEM) && dmem_ack && (w_op == OP_LD));
    assign w_rf_wdata = (r_state == MEM) ? dmem_rdata : w_alu_res;

    // Branch offset is the b field sign-extended (-4..+3).
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_bz  = (w_rdata_a == '0) ? (r_pc + PC_W'(w_rb_s)) : w_pc_inc;

    assign w_retired_inc = (r_retired == '1) ? r_retired : (r_retired + CNT_W'(1));

    assign w_busy = (r_state == FETCH) || (r_state == EXEC) ||
                    (r_state == MEM)   || (r_state == WB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_cycles  <= '0;
            r_retired <= '0;
        end else begin
            if (w_busy && (r_cycles != '1)) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= (r_pc == C_DONE_PC) ? HALT : FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    case (w_op)
                        OP_LD, OP_ST: r_state <= MEM;
                        OP_BZ: begin
                            r_pc      <= w_pc_bz;
                            r_retired <= w_retired_inc;
                            r_state   <= (w_pc_bz == C_DONE_PC) ? HALT : FETCH;
                        end
                        default: r_state <= WB;
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        r_pc      <= w_pc_inc;
                        r_retired <= w_retired_inc;
                        r_state   <= (w_pc_inc == C_DONE_PC) ? HALT : FETCH;
                    end
                end
                WB: begin
                    r_pc      <= w_pc_inc;
                    r_retired <= w_retired_inc;
                    r_state   <= (w_pc_inc == C_DONE_PC) ? HALT : FETCH;
                end
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Requests decode straight from the state register, so the async reset
    // removes them in the same cycle and any later ack finds the core idle.
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign dmem_req    = (r_state == MEM);
    assign dmem_we     = (r_state == MEM) && (w_op == OP_ST);
    assign dmem_addr   = w_rdata_b;
    assign dmem_wdata  = w_rdata_a;
    assign busy        = w_busy;
    assign done        = (r_state == HALT);
    assign cycle_count = r_cycles;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_core
//  Description : Self-checking bench for multicycle_core: table-driven ALU
//                vectors plus directed stall, load/store, branch, halt and
//                reset-during-access sequences.
//  Revision    : 1.0  initial multicycle release
// ============================================================================
module tb_multicycle_core;

    localparam logic [8:0] NOP = 9'b100_111_000;   // ADDI R7,0

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [11:0] imem_addr;
    logic [8:0]  imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        busy, done;
    logic [15:0] cycle_count, retired;

    logic        h_start = 1'b0;
    logic        h_imem_req, h_imem_ack = 1'b0;
    logic [11:0] h_imem_addr;
    logic [8:0]  h_imem_rdata = 9'b100_001_001;     // ADDI R1,1
    logic        h_dmem_req, h_dmem_we;
    logic        h_dmem_ack = 1'b0;
    logic [7:0]  h_dmem_addr, h_dmem_wdata;
    logic [7:0]  h_dmem_rdata = '0;
    logic        h_busy, h_done;
    logic [15:0] h_cycle_count, h_retired;

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .busy(busy), .done(done), .cycle_count(cycle_count), .retired(retired)
    );

    multicycle_core #(.DONE_PC(4)) dut_h (
        .clk(clk), .reset(reset), .start(h_start),
        .imem_req(h_imem_req), .imem_addr(h_imem_addr), .imem_ack(h_imem_ack), .imem_rdata(h_imem_rdata),
        .dmem_req(h_dmem_req), .dmem_we(h_dmem_we), .dmem_addr(h_dmem_addr), .dmem_wdata(h_dmem_wdata),
        .dmem_ack(h_dmem_ack), .dmem_rdata(h_dmem_rdata),
        .busy(h_busy), .done(h_done), .cycle_count(h_cycle_count), .retired(h_retired)
    );

    // ---------------- memory models ----------------
    logic [8:0] imem  [64];
    logic [7:0] dinit [256];
    logic [7:0] dmem  [256];
    int imem_lat = 0, dmem_lat = 0;
    int i_cnt = 0, d_cnt = 0, d_len = 0;
    bit force_dack = 1'b0;
    int st_count = 0;
    logic [7:0] st_addr [8];
    logic [7:0] st_data [8];
    int st_len [8];

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            for (int k = 0; k < 256; k++) dmem[k] = dinit[k];
            st_count = 0;
        end
        if (imem_req) begin
            imem_rdata = imem[imem_addr[5:0]];
            if (i_cnt >= imem_lat) begin imem_ack = 1'b1; i_cnt = 0; end
            else begin imem_ack = 1'b0; i_cnt++; end
        end else begin
            imem_ack = 1'b0; i_cnt = 0;
        end
        if (force_dack) begin
            dmem_ack = 1'b1;
        end else if (dmem_req) begin
            d_len++;
            if (d_cnt >= dmem_lat) begin
                dmem_ack = 1'b1; d_cnt = 0;
                if (dmem_we) begin
                    dmem[dmem_addr] = dmem_wdata;
                    if (st_count < 8) begin
                        st_addr[st_count] = dmem_addr;
                        st_data[st_count] = dmem_wdata;
                        st_len[st_count]  = d_len;
                    end
                    st_count++;
                end else begin
                    dmem_rdata = dmem[dmem_addr];
                end
                d_len = 0;
            end else begin
                dmem_ack = 1'b0; d_cnt++;
            end
        end else begin
            dmem_ack = 1'b0; d_cnt = 0; d_len = 0;
        end
        h_imem_ack = h_imem_req;
    end

    // ---------------- checking helpers ----------------
    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 64; k++) imem[k] = NOP;
        for (int k = 0; k < 256; k++) dinit[k] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; force_dack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_retired(input int n, input int limit, input string tag);
        int k = 0;
        while (int'(retired) < n && k < limit) begin @(negedge clk); k++; end
        if (int'(retired) < n) check({tag, "_timeout"}, 32'(retired), 32'(n));
    endtask

    task automatic wait_stores(input int n, input int limit, input string tag);
        int k = 0;
        while (st_count < n && k < limit) begin @(negedge clk); k++; end
        if (st_count < n) check({tag, "_timeout"}, 32'(st_count), 32'(n));
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] imm;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        bit addr_bad;
        int k;

        vecs[0] = '{3'b000, 8'h10, 8'h25, 3'd0, 8'h35};
        vecs[1] = '{3'b000, 8'hF0, 8'h20, 3'd0, 8'h10};
        vecs[2] = '{3'b001, 8'h10, 8'h25, 3'd0, 8'hEB};
        vecs[3] = '{3'b001, 8'h50, 8'h05, 3'd0, 8'h4B};
        vecs[4] = '{3'b010, 8'hF0, 8'h3C, 3'd0, 8'h30};
        vecs[5] = '{3'b011, 8'hF0, 8'h3C, 3'd0, 8'hCC};
        vecs[6] = '{3'b100, 8'hFF, 8'h00, 3'd1, 8'h00};
        vecs[7] = '{3'b100, 8'h05, 8'h00, 3'd7, 8'h0C};

        // ---- reset state ----
        clear_mem();
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_cycles", 32'(cycle_count), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_h_done", 32'(h_done), 0);

        // ---- two ADDIs, zero-latency fetch ----
        imem[0] = 9'b100_001_101;   // ADDI R1,5
        imem[1] = 9'b100_001_011;   // ADDI R1,3
        imem[2] = 9'b110_001_000;   // ST R1,[R0]
        kick();
        wait_retired(2, 50, "addi_ret");
        check("addi_retired", 32'(retired), 2);
        check("addi_cycles", 32'(cycle_count), 6);
        wait_stores(1, 50, "addi_st");
        check("addi_r1", 32'(st_data[0]), 8'h08);
        check("addi_st_addr", 32'(st_addr[0]), 8'h00);

        // ---- fetch stall of 4 cycles ----
        imem_lat = 4;
        do_reset();
        start = 1'b1;
        run = 0; addr_bad = 1'b0; k = 0;
        while (k < 30) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (imem_req) begin
                run++;
                if (imem_addr != 12'd0) addr_bad = 1'b1;
            end else if (run > 0) begin
                break;
            end
        end
        check("stall_req_cycles", 32'(run), 5);
        check("stall_addr_steady", 32'(addr_bad), 0);
        wait_retired(2, 100, "stall_ret");
        check("stall_cycles", 32'(cycle_count), 14);
        imem_lat = 0;

        // ---- table-driven ALU vectors ----
        for (int i = 0; i < 8; i++) begin
            clear_mem();
            imem[0] = 9'b101_001_000;   // LD R1,[R0]
            imem[1] = 9'b100_010_001;   // ADDI R2,1
            imem[2] = 9'b101_011_010;   // LD R3,[R2]
            imem[3] = (vecs[i].op == 3'b100) ? {3'b100, 3'd1, vecs[i].imm}
                                             : {vecs[i].op, 3'd1, 3'd3};
            imem[4] = 9'b110_001_010;   // ST R1,[R2]
            dinit[0] = vecs[i].x;
            dinit[1] = vecs[i].y;
            dmem_lat = i % 3;
            do_reset();
            kick();
            wait_stores(1, 200, $sformatf("alu_vec%0d", i));
            check($sformatf("alu_vec%0d", i), 32'(st_data[0]), 32'(vecs[i].exp));
        end

        // ---- load/store with 2-cycle data latency ----
        clear_mem();
        imem[0] = 9'b100_010_111;   // ADDI R2,7
        imem[1] = 9'b101_011_000;   // LD R3,[R0]
        imem[2] = 9'b110_011_010;   // ST R3,[R2]
        imem[3] = 9'b101_100_010;   // LD R4,[R2]
        imem[4] = 9'b110_100_000;   // ST R4,[R0]
        dinit[0] = 8'h5A;
        dmem_lat = 2;
        do_reset();
        kick();
        wait_stores(2, 200, "ls");
        check("ls_st_addr", 32'(st_addr[0]), 8'h07);
        check("ls_st_data", 32'(st_data[0]), 8'h5A);
        check("ls_st_len", 32'(st_len[0]), 3);
        check("ls_ld_r4", 32'(st_data[1]), 8'h5A);
        check("ls_st2_addr", 32'(st_addr[1]), 8'h00);
        check("ls_st2_len", 32'(st_len[1]), 3);
        dmem_lat = 0;

        // ---- branches ----
        clear_mem();
        imem[7]  = 9'b111_000_011;  // BZ R0,+3   (7 -> 10)
        imem[8]  = 9'b100_000_001;  // ADDI R0,1
        imem[10] = 9'b111_000_110;  // BZ R0,-2
        do_reset();
        kick();
        wait_retired(8, 100, "bz_fwd");
        check("bz_fwd_addr", 32'(imem_addr), 10);
        wait_retired(9, 50, "bz_back");
        check("bz_back_addr", 32'(imem_addr), 8);
        wait_retired(12, 100, "bz_nt");
        check("bz_not_taken_addr", 32'(imem_addr), 11);

        // ---- halt at DONE_PC=4 ----
        h_start = 1'b1;
        @(negedge clk);
        h_start = 1'b0;
        k = 0;
        while (!h_done && k < 100) begin @(negedge clk); k++; end
        check("halt_done", 32'(h_done), 1);
        check("halt_retired", 32'(h_retired), 4);
        check("halt_cycles", 32'(h_cycle_count), 12);
        check("halt_imem_req", 32'(h_imem_req), 0);
        check("halt_busy", 32'(h_busy), 0);
        for (int p = 0; p < 3; p++) begin
            h_start = 1'b1; @(negedge clk);
            h_start = 1'b0; @(negedge clk);
        end
        check("halt_sticky_done", 32'(h_done), 1);
        check("halt_retired_hold", 32'(h_retired), 4);
        check("halt_imem_req_hold", 32'(h_imem_req), 0);

        // ---- reset during a MEM wait, then a late ack ----
        clear_mem();
        imem[0] = 9'b101_001_000;   // LD R1,[R0]
        dinit[0] = 8'h33;
        dmem_lat = 5;
        do_reset();
        kick();
        k = 0;
        while (!dmem_req && k < 50) begin @(negedge clk); k++; end
        check("mid_mem_req_seen", 32'(dmem_req), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_dmem_req", 32'(dmem_req), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        force_dack = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("late_ack_busy", 32'(busy), 0);
        check("late_ack_retired", 32'(retired), 0);
        check("late_ack_cycles", 32'(cycle_count), 0);
        force_dack = 1'b0;
        imem[0] = 9'b110_001_000;   // ST R1,[R0]
        dmem_lat = 0;
        kick();
        check("restart_addr", 32'(imem_addr), 0);
        wait_stores(1, 50, "restart_st");
        check("restart_r1", 32'(st_data[0]), 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
